// File: rtl/cpu_types_pkg.sv
// Shared CPU types: BTB entry layout and direction-counter constants.
// No logic; widths here set the default BTB geometry.
// Not applicable (type/constant definitions only).
package cpu_types_pkg;

  localparam int CPU_PC_W        = 32;
  localparam int CPU_BTB_ENTRIES = 16;
  localparam int CPU_CTR_BITS    = 2;
  localparam int CPU_IDX_W       = $clog2(CPU_BTB_ENTRIES);
  localparam int CPU_TAG_W       = CPU_PC_W - 2 - CPU_IDX_W;

  // Allocation value: MSB set, lower bits clear (1 when the counter is 1 bit).
  localparam logic [CPU_CTR_BITS-1:0] CTR_WEAK_TAKEN =
    CPU_CTR_BITS'(1) << (CPU_CTR_BITS - 1);

  typedef struct packed {
    logic                    valid;
    logic [CPU_TAG_W-1:0]    tag;
    logic [CPU_PC_W-1:0]     target;
    logic [CPU_CTR_BITS-1:0] ctr;
  } btb_entry_t;

endpackage

// File: rtl/branch_predictor_if.sv
// IF/MEM-stage connection to the branch predictor.
// Lookup outputs are combinational; updates take effect at the next edge.
// No backpressure: the datapath gates lookup_en/update_en itself.
interface branch_predictor_if
  import cpu_types_pkg::*;
#(
  parameter int PC_W = CPU_PC_W
);
  logic            lookup_en;
  logic [PC_W-1:0] lookup_pc;
  logic            pred_hit;
  logic            pred_taken;
  logic [PC_W-1:0] pred_target;
  logic            update_en;
  logic [PC_W-1:0] update_pc;
  logic            update_taken;
  logic [PC_W-1:0] update_target;
  logic            update_pred_taken;
  logic [PC_W-1:0] update_pred_target;
  logic            flush_all;
  logic            mispredict;
  logic [31:0]     stat_lookups;
  logic [31:0]     stat_mispredicts;

  modport master (
    output lookup_en, lookup_pc, update_en, update_pc, update_taken, update_target,
           update_pred_taken, update_pred_target, flush_all,
    input  pred_hit, pred_taken, pred_target, mispredict, stat_lookups, stat_mispredicts
  );

  modport slave (
    input  lookup_en, lookup_pc, update_en, update_pc, update_taken, update_target,
           update_pred_taken, update_pred_target, flush_all,
    output pred_hit, pred_taken, pred_target, mispredict, stat_lookups, stat_mispredicts
  );
endinterface

// File: rtl/sat_counter.sv
// Width-parametric saturating up/down counter with parallel load.
// One-cycle latency: the new value appears after the rising edge.
// No backpressure; load beats inc, inc beats dec.
module sat_counter #(
  parameter int W = 2
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         inc,
  input  logic         dec,
  input  logic         load,
  input  logic [W-1:0] load_val,
  output logic [W-1:0] q
);
  localparam logic [W-1:0] MAX = {W{1'b1}};

  logic [W-1:0] cnt_q, cnt_d;

  // Next value: load, or step toward a bound without wrapping.
  always_comb begin
    cnt_d = cnt_q;
    if (load) begin
      cnt_d = load_val;
    end else if (inc) begin
      if (cnt_q != MAX) cnt_d = cnt_q + W'(1);
    end else if (dec) begin
      if (cnt_q != '0) cnt_d = cnt_q - W'(1);
    end
  end

  // Counter register, cleared asynchronously.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) cnt_q <= '0;
    else        cnt_q <= cnt_d;
  end

  assign q = cnt_q;
endmodule

// File: rtl/branch_predictor.sv
// Direct-mapped BTB with saturating direction counters, mispredict flag and stats.
// Lookup and mispredict are zero-latency; updates/flush visible the cycle after the edge.
// No backpressure; an update_en held high re-applies the update every cycle.
module branch_predictor
  import cpu_types_pkg::*;
#(
  // Entry layout comes from btb_entry_t, so these must agree with cpu_types_pkg.
  parameter int BTB_ENTRIES = CPU_BTB_ENTRIES,
  parameter int CTR_BITS    = CPU_CTR_BITS,
  parameter int PC_W        = CPU_PC_W
) (
  input  logic               CLK,
  input  logic               nRST,
  branch_predictor_if.slave  bp
);
  localparam int IDX_W = $clog2(BTB_ENTRIES);
  localparam int TAG_W = PC_W - 2 - IDX_W;

  logic [BTB_ENTRIES-1:0]               valid_q, valid_d;
  logic [TAG_W-1:0]                     tag_q    [BTB_ENTRIES];
  logic [TAG_W-1:0]                     tag_d    [BTB_ENTRIES];
  logic [PC_W-1:0]                      target_q [BTB_ENTRIES];
  logic [PC_W-1:0]                      target_d [BTB_ENTRIES];
  logic [BTB_ENTRIES-1:0][CTR_BITS-1:0] ctr_q;
  logic [BTB_ENTRIES-1:0]               ctr_inc, ctr_dec, ctr_load;
  btb_entry_t                           btb      [BTB_ENTRIES];

  logic [IDX_W-1:0] lk_idx, up_idx;
  logic [TAG_W-1:0] lk_tag, up_tag;
  btb_entry_t       lk_ent, up_ent;
  logic             lk_hit, lk_taken, up_hit;
  logic [1:0]       unused_pc_lsbs;

  assign lk_idx = bp.lookup_pc[IDX_W+1:2];
  assign lk_tag = bp.lookup_pc[PC_W-1:IDX_W+2];
  assign up_idx = bp.update_pc[IDX_W+1:2];
  assign up_tag = bp.update_pc[PC_W-1:IDX_W+2];
  assign unused_pc_lsbs = bp.update_pc[1:0];

  // Assemble the per-entry view read by both ports.
  always_comb begin
    for (int i = 0; i < BTB_ENTRIES; i++) begin
      btb[i] = '{valid: valid_q[i], tag: tag_q[i], target: target_q[i], ctr: ctr_q[i]};
    end
  end

  // Fetch-side lookup; reads register contents, so same-cycle updates are not seen.
  always_comb begin
    lk_ent   = btb[lk_idx];
    lk_hit   = lk_ent.valid && (lk_ent.tag == lk_tag);
    lk_taken = lk_hit && (lk_ent.ctr >= CTR_WEAK_TAKEN);
  end

  assign bp.pred_hit    = lk_hit;
  assign bp.pred_taken  = lk_taken;
  assign bp.pred_target = lk_taken ? lk_ent.target : bp.lookup_pc + PC_W'(4);

  assign up_ent = btb[up_idx];
  assign up_hit = up_ent.valid && (up_ent.tag == up_tag);

  assign bp.mispredict = bp.update_en &&
    ((bp.update_taken != bp.update_pred_taken) ||
     (bp.update_taken && (bp.update_target != bp.update_pred_target)));

  // Resolve-side update: train on a hit, allocate on a taken miss; flush overrides.
  always_comb begin
    valid_d  = valid_q;
    tag_d    = tag_q;
    target_d = target_q;
    ctr_inc  = '0;
    ctr_dec  = '0;
    ctr_load = '0;
    if (bp.flush_all) begin
      valid_d = '0;
    end else if (bp.update_en) begin
      if (up_hit) begin
        if (bp.update_taken) begin
          ctr_inc[up_idx]  = 1'b1;
          target_d[up_idx] = bp.update_target;
        end else begin
          ctr_dec[up_idx]  = 1'b1;
        end
      end else if (bp.update_taken) begin
        valid_d[up_idx]  = 1'b1;
        tag_d[up_idx]    = up_tag;
        target_d[up_idx] = bp.update_target;
        ctr_load[up_idx] = 1'b1;
      end
    end
  end

  // Entry valid/tag/target registers.
  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      valid_q  <= '0;
      tag_q    <= '{default: '0};
      target_q <= '{default: '0};
    end else begin
      valid_q  <= valid_d;
      tag_q    <= tag_d;
      target_q <= target_d;
    end
  end

  for (genvar i = 0; i < BTB_ENTRIES; i++) begin : g_ctr
    sat_counter #(.W(CTR_BITS)) u_ctr (
      .clk(CLK), .rst_n(nRST), .inc(ctr_inc[i]), .dec(ctr_dec[i]),
      .load(ctr_load[i]), .load_val(CTR_WEAK_TAKEN), .q(ctr_q[i])
    );
  end

  sat_counter #(.W(32)) u_stat_lookups (
    .clk(CLK), .rst_n(nRST), .inc(bp.lookup_en), .dec(1'b0),
    .load(1'b0), .load_val(32'h0), .q(bp.stat_lookups)
  );

  sat_counter #(.W(32)) u_stat_mispredicts (
    .clk(CLK), .rst_n(nRST), .inc(bp.mispredict), .dec(1'b0),
    .load(1'b0), .load_val(32'h0), .q(bp.stat_mispredicts)
  );
endmodule

// File: doc/branch_predictor.md
Name: branch_predictor

Overview:
- Direct-mapped branch target buffer (BTB) with per-entry saturating direction counters.
- Lets the pipelined datapath redirect fetch in IF instead of waiting for branch resolution in MEM.
- The IF stage looks up the current PC combinationally; the MEM stage writes back resolved branch outcomes.
- Also flags mispredictions and keeps lookup/mispredict statistics for performance runs.

Parameters:
- BTB_ENTRIES, 16: number of entries; power of 2, at least 2.
- CTR_BITS, 2: direction counter width, 1..4.
- PC_W, 32: PC and target width.
- IDX_W (localparam), log2(BTB_ENTRIES): index width.
- TAG_W (localparam), PC_W-2-IDX_W: tag width.

Ports:
- CLK  in  1  system clock, rising edge.
- nRST  in  1  asynchronous active-low reset.
- lookup_en  in  1  IF stage fetching a valid instruction this cycle (ihit and not stalled).
- lookup_pc  in  PC_W  current fetch PC.
- pred_hit  out  1  lookup_pc hits a valid entry.
- pred_taken  out  1  predicted taken.
- pred_target  out  PC_W  predicted next PC.
- update_en  in  1  resolved branch in MEM this cycle; must be a single-cycle pulse per branch.
- update_pc  in  PC_W  PC of the resolved branch.
- update_taken  in  1  actual branch direction.
- update_target  in  PC_W  actual branch target.
- update_pred_taken  in  1  prediction carried down the pipe with the branch.
- update_pred_target  in  PC_W  predicted target carried down the pipe.
- flush_all  in  1  invalidate all entries.
- mispredict  out  1  combinational; the resolved branch was mispredicted.
- stat_lookups  out  32  count of lookup_en cycles.
- stat_mispredicts  out  32  count of mispredicted updates.

Behaviour:
- Address split: idx = pc[IDX_W+1:2]; tag = pc[PC_W-1:IDX_W+2]. pc[1:0] is ignored.
- Storage per entry: valid, tag[TAG_W], target[PC_W], ctr[CTR_BITS].
- Reset (asynchronous):
  - all valid = 0, all ctr = 0, targets/tags = 0;
  - stat counters = 0;
  - outputs therefore read pred_hit = 0, pred_taken = 0, pred_target = lookup_pc+4.
- Lookup (combinational, zero latency, independent of lookup_en):
  - pred_hit = valid[idx] && tag[idx]==tag(lookup_pc);
  - pred_taken = pred_hit && ctr[idx][CTR_BITS-1];
  - pred_target = pred_taken ? target[idx] : lookup_pc+4, with the add modulo 2^PC_W.
- mispredict = update_en && ((update_taken != update_pred_taken) || (update_taken && update_target != update_pred_target)).
- Update, on the rising edge when update_en=1:
  - Hit (valid and tag match): ctr saturating-increments if taken, else saturating-decrements. Saturation bounds are 0 and 2^CTR_BITS-1; no wrap. target is written only if taken.
  - Miss and taken: allocate the entry, overwriting any aliased entry. Set valid=1, tag, target, and ctr = 2^(CTR_BITS-1) (weakly taken; value 1 when CTR_BITS=1).
  - Miss and not taken: no state change.
- Simultaneous lookup and update to the same index: the lookup returns pre-update contents (read-before-write). The new contents are visible the next cycle.
- flush_all, synchronous:
  - clears every valid bit at the edge;
  - ctr/target/tag are left unchanged;
  - if update_en is asserted in the same cycle, flush wins and no allocation or counter change occurs;
  - statistics are not cleared.
- Statistics:
  - stat_lookups increments on each edge with lookup_en=1;
  - stat_mispredicts increments on each edge with mispredict=1;
  - both saturate at 32'hFFFF_FFFF.
- No internal stall handling: the datapath gates lookup_en/update_en itself. An update_en held high repeats the update every cycle.

Decomposition:
- cpu_types_pkg gains:
  - btb_entry_t, a packed struct (valid, tag, target, ctr), parametrised via the package's PC width;
  - CTR_WEAK_TAKEN helper constant.
- One natural sub-module: sat_counter (width-parametric, inc/dec/load, saturating). It is used for the direction counters and both statistic counters; the 32-bit statistic instances use only saturating increment.

Test Plan:
- Cold lookup: after reset, lookup_pc=0x0000_0040 gives pred_hit=0, pred_taken=0, pred_target=0x0000_0044.
- Allocate, then hit: update_pc=0x40, taken=1, target=0x100 (pred_taken=0) gives mispredict=1 and stat_mispredicts=1. On the next cycle, lookup 0x40 gives hit=1, taken=1, target=0x100, and ctr=2.
- Saturation (CTR_BITS=2):
  - three more taken updates on 0x40 leave ctr at 3;
  - then two not-taken leave ctr=1, so pred_taken=0 and pred_target=0x44;
  - two further not-taken leave ctr=0, with no wrap.
- Aliasing (BTB_ENTRIES=16): 0x40 and 0x80 share idx 0. A taken update on 0x80 (target 0x200) replaces the entry, so lookup 0x40 gives pred_hit=0. A not-taken update on an absent PC leaves the BTB unchanged.
- Same-cycle events:
  - lookup 0x40 while updating 0x40 to target 0x300: the current cycle shows the old target 0x100, the next cycle shows 0x300;
  - flush_all together with update_en: all entries invalid next cycle, no allocation.
- Reset mid-run: assert nRST low asynchronously between edges. The BTB becomes empty and stats read 0 immediately, without waiting for an edge.
